dmem_lane_ctrl: RTL and testbench

//   Initiator side of the byte-lane data-memory interface. Accepts one load/store per handshake from the
//   MEM stage and splits it across four 8-bit BRAM lanes. Each lane has its own address and enables,
//   so misaligned accesses complete in one cycle. Lane outputs are gathered and sign/zero-extended.

---
 rtl/dmem_lane_ctrl.sv | 145 ++++++++++++++
 tb/tb_dmem_lane_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lane_ctrl.sv
// rtl/dmem_lane_ctrl.sv - byte-lane data-memory initiator: splits loads/stores over four 8-bit BRAM lanes
// and gathers lane read data back into a sign/zero-extended word one cycle later.
module dmem_lane_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_req_valid,
  output logic                        o_req_ready,
  input  logic                        i_req_we,
  input  logic [2:0]                  i_req_funct3,
  input  logic [ADDR_WIDTH-1:0]       i_req_addr,
  input  logic [31:0]                 i_req_wdata,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [31:0]                 o_rsp_rdata,
  output logic                        o_rsp_err,
  output logic [4*(ADDR_WIDTH-2)-1:0] o_lane_w_addr,
  output logic [4*(ADDR_WIDTH-2)-1:0] o_lane_r_addr,
  output logic [3:0]                  o_lane_we,
  output logic [3:0]                  o_lane_re,
  output logic [31:0]                 o_lane_din,
  input  logic [31:0]                 i_lane_dout
);

  localparam int LW = ADDR_WIDTH - 2;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic        r_err;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic        w_accept;
  logic        w_legal;
  logic [2:0]  w_nbytes;
  logic [31:0] w_ext;

  assign o_req_ready = !i_rst && ((r_state == S_IDLE) || i_rsp_ready);
  assign w_accept    = i_req_valid && o_req_ready;
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_err   = o_rsp_valid && r_err;

  always_comb begin
    w_legal = 1'b0;
    if (i_req_we) begin
      w_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) || (i_req_funct3 == 3'b010);
    end else begin
      w_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) || (i_req_funct3 == 3'b010) ||
                (i_req_funct3 == 3'b100) || (i_req_funct3 == 3'b101);
    end
  end

  always_comb begin
    case (i_req_funct3[1:0])
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // Each lane works out which access byte it carries, so misaligned and wrapping accesses need no special case.
  always_comb begin
    logic [1:0]            v_idx;
    logic [ADDR_WIDTH-1:0] v_baddr;
    o_lane_we     = '0;
    o_lane_re     = '0;
    o_lane_w_addr = '0;
    o_lane_r_addr = '0;
    o_lane_din    = '0;
    for (int k = 0; k < 4; k++) begin
      v_idx   = 2'(k) - i_req_addr[1:0];
      v_baddr = i_req_addr + {{(ADDR_WIDTH-2){1'b0}}, v_idx};
      if (w_accept && w_legal && ({1'b0, v_idx} < w_nbytes)) begin
        if (i_req_we) begin
          o_lane_we[k]               = 1'b1;
          o_lane_w_addr[k*LW +: LW]  = v_baddr[ADDR_WIDTH-1:2];
          o_lane_din[8*k +: 8]       = i_req_wdata[8*v_idx +: 8];
        end else begin
          o_lane_re[k]               = 1'b1;
          o_lane_r_addr[k*LW +: LW]  = v_baddr[ADDR_WIDTH-1:2];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = S_RESP;
    end else if ((r_state == S_RESP) && i_rsp_ready) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we     <= i_req_we;
        r_err    <= !w_legal;
        r_funct3 <= i_req_funct3;
        r_off    <= i_req_addr[1:0];
      end
    end
  end

  // Lane read data is gathered straight from the BRAM outputs, which hold while no read is enabled.
  always_comb begin
    logic [1:0] v_l1;
    logic [1:0] v_l2;
    logic [1:0] v_l3;
    logic [7:0] v_b0;
    logic [7:0] v_b1;
    logic [7:0] v_b2;
    logic [7:0] v_b3;
    v_l1 = r_off + 2'd1;
    v_l2 = r_off + 2'd2;
    v_l3 = r_off + 2'd3;
    v_b0 = i_lane_dout[8*r_off +: 8];
    v_b1 = i_lane_dout[8*v_l1 +: 8];
    v_b2 = i_lane_dout[8*v_l2 +: 8];
    v_b3 = i_lane_dout[8*v_l3 +: 8];
    case (r_funct3)
      3'b000:  w_ext = {{24{v_b0[7]}}, v_b0};
      3'b001:  w_ext = {{16{v_b1[7]}}, v_b1, v_b0};
      3'b010:  w_ext = {v_b3, v_b2, v_b1, v_b0};
      3'b100:  w_ext = {24'h0, v_b0};
      3'b101:  w_ext = {16'h0, v_b1, v_b0};
      default: w_ext = 32'h0;
    endcase
  end

  assign o_rsp_rdata = (o_rsp_valid && !r_we && !r_err) ? w_ext : 32'h0;

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// tb/tb_dmem_lane_ctrl.sv - table-driven scoreboard bench for dmem_lane_ctrl with a four-lane byte BRAM model.
module tb_dmem_lane_ctrl;

  localparam int AW = 8;
  localparam int LW = AW - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [4*LW-1:0] lane_w_addr;
  logic [4*LW-1:0] lane_r_addr;
  logic [3:0]    lane_we;
  logic [3:0]    lane_re;
  logic [31:0]   lane_din;
  logic [31:0]   lane_dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_lane_ctrl #(.ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_lane_w_addr(lane_w_addr), .o_lane_r_addr(lane_r_addr),
    .o_lane_we(lane_we), .o_lane_re(lane_re), .o_lane_din(lane_din), .i_lane_dout(lane_dout)
  );

  logic [7:0] mem [4][64];

  initial begin
    lane_dout = 32'h0;
    for (int k = 0; k < 4; k++)
      for (int w = 0; w < 64; w++)
        mem[k][w] = 8'h00;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (lane_we[k]) mem[k][lane_w_addr[k*LW +: LW]] <= lane_din[8*k +: 8];
      if (lane_re[k]) lane_dout[8*k +: 8] <= mem[k][lane_r_addr[k*LW +: LW]];
    end
  end

  typedef struct {
    logic          we;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    logic [3:0]    exp_we;
    logic [3:0]    exp_re;
    logic          chk_lane;
    logic [4*LW-1:0] exp_waddr;
    logic [31:0]   exp_din;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [AW-1:0] addr, logic [31:0] wdata,
                              logic [31:0] exp_rdata, logic exp_err, logic [3:0] exp_we, logic [3:0] exp_re,
                              logic chk_lane, logic [4*LW-1:0] exp_waddr, logic [31:0] exp_din);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_we = exp_we; v.exp_re = exp_re;
    v.chk_lane = chk_lane; v.exp_waddr = exp_waddr; v.exp_din = exp_din;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rsp();
    rsp_t e;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [AW-1:0] a, input logic [31:0] d);
    req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
  endtask

  initial begin
    rsp_t e;
    rst = 1'b1;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 3'b000, '0, 32'h0);

    //             we   f3      addr   wdata         rdata         err   we       re       chk  waddr       din
    vecs.push_back(mk(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 4'b1111, 4'b0000, 1'b1, 24'h104104, 32'hDEADBEEF));
    vecs.push_back(mk(1'b0, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, 4'b1111, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b1, 3'b010, 8'h0E, 32'h11223344, 32'h00000000, 1'b0, 4'b1111, 4'b0000, 1'b1, 24'h0C3104, 32'h33441122));
    vecs.push_back(mk(1'b0, 3'b010, 8'h0E, 32'h0,        32'h11223344, 1'b0, 4'b0000, 4'b1111, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b1, 3'b010, 8'h10, 32'h80000000, 32'h00000000, 1'b0, 4'b1111, 4'b0000, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b0, 3'b000, 8'h13, 32'h0,        32'hFFFFFF80, 1'b0, 4'b0000, 4'b1000, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b0, 3'b100, 8'h13, 32'h0,        32'h00000080, 1'b0, 4'b0000, 4'b1000, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b0, 3'b001, 8'h12, 32'h0,        32'hFFFF8000, 1'b0, 4'b0000, 4'b1100, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b0, 3'b101, 8'h12, 32'h0,        32'h00008000, 1'b0, 4'b0000, 4'b1100, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b1, 3'b010, 8'hFE, 32'hA1B2C3D4, 32'h00000000, 1'b0, 4'b1111, 4'b0000, 1'b1, 24'hFFF000, 32'hC3D4A1B2));
    vecs.push_back(mk(1'b0, 3'b010, 8'hFE, 32'h0,        32'hA1B2C3D4, 1'b0, 4'b0000, 4'b1111, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b0, 3'b000, 8'hFF, 32'h0,        32'hFFFFFFC3, 1'b0, 4'b0000, 4'b1000, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b0, 3'b001, 8'h00, 32'h0,        32'hFFFFA1B2, 1'b0, 4'b0000, 4'b0011, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b0, 3'b011, 8'h10, 32'h0,        32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b1, 3'b011, 8'h10, 32'h12345678, 32'h00000000, 1'b1, 4'b0000, 4'b0000, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b1, 3'b001, 8'h21, 32'h00007F01, 32'h00000000, 1'b0, 4'b0110, 4'b0000, 1'b1, 24'h008200, 32'h007F0100));
    vecs.push_back(mk(1'b0, 3'b001, 8'h21, 32'h0,        32'h00007F01, 1'b0, 4'b0000, 4'b0110, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b0, 3'b100, 8'h22, 32'h0,        32'h0000007F, 1'b0, 4'b0000, 4'b0100, 1'b0, 24'h0,      32'h0));
    vecs.push_back(mk(1'b0, 3'b010, 8'h30, 32'h0,        32'h00000000, 1'b0, 4'b0000, 4'b1111, 1'b0, 24'h0,      32'h0));

    // Reset: a store presented during reset must be ignored entirely.
    @(negedge clk);
    drive(1'b1, 1'b1, 3'b010, 8'h30, 32'h55555555);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_lane_we", {28'd0, lane_we}, 32'd0);
    chk("rst_lane_re", {28'd0, lane_re}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, '0, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      check_rsp();
      drive(1'b1, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      #1;
      chk($sformatf("accept_%0d", i), {31'd0, req_ready}, 32'd1);
      chk($sformatf("lane_we_%0d", i), {28'd0, lane_we}, {28'd0, vecs[i].exp_we});
      chk($sformatf("lane_re_%0d", i), {28'd0, lane_re}, {28'd0, vecs[i].exp_re});
      if (vecs[i].chk_lane) begin
        chk($sformatf("lane_waddr_%0d", i), {8'd0, lane_w_addr}, {8'd0, vecs[i].exp_waddr});
        chk($sformatf("lane_din_%0d", i), lane_din, vecs[i].exp_din);
      end
      if (req_ready) begin
        e.rdata = vecs[i].exp_rdata;
        e.err   = vecs[i].exp_err;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    check_rsp();
    drive(1'b0, 1'b0, 3'b000, '0, 32'h0);
    @(negedge clk);
    chk("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    // Backpressure: response held for three cycles, then exactly one handshake.
    drive(1'b1, 1'b0, 3'b010, 8'h10, 32'h0);
    #1;
    chk("bp_accept", {31'd0, req_ready}, 32'd1);
    e.rdata = 32'h80000000;
    e.err   = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 8'h00, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h80000000);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_lane_re", {28'd0, lane_re}, 32'd0);
      chk("bp_lane_we", {28'd0, lane_we}, 32'd0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 3'b000, '0, 32'h0);
    rsp_ready = 1'b1;
    #1;
    check_rsp();
    @(negedge clk);
    chk("bp_one_handshake", {31'd0, rsp_valid}, 32'd0);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Reset while a response is pending drops it.
    drive(1'b1, 1'b0, 3'b010, 8'hFE, 32'h0);
    #1;
    chk("rr_accept", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 8'h10, 32'h0);
    rst = 1'b1;
    #1;
    chk("rr_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rr_lane_re", {28'd0, lane_re}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'b000, '0, 32'h0);
    #1;
    chk("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rr_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    chk("rr_still_idle", {31'd0, rsp_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
